// File: rtl/aurora_bist_seq.sv
// rtl/aurora_bist_seq.sv - PRBS BIST run sequencer for the Aurora MAC; lock timeout enabled by AURORA_BIST_SEQ_TIMEOUT_EN
module aurora_bist_seq #(
    parameter int SETTLE_CYCLES = 16,
    parameter int LOCK_TIMEOUT  = 65535
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        start,
    input  logic        abort,
    input  logic        channel_up,
    input  logic [5:0]  rate,
    input  logic [15:0] dwell_cycles,
    input  logic [15:0] drain_cycles,
    input  logic [47:0] min_samps,
    output logic        bist_gen_en,
    output logic        bist_checker_en,
    output logic        bist_loopback_req,
    output logic [5:0]  bist_gen_rate,
    input  logic        bist_checker_locked,
    input  logic [47:0] bist_checker_samps,
    input  logic [47:0] bist_checker_errors,
    output logic        busy,
    output logic        done,
    output logic        pass,
    output logic [2:0]  fail_code,
    output logic [47:0] result_samps,
    output logic [47:0] result_errors
);

    typedef enum logic [2:0] {
        S_IDLE, S_ARM, S_LOCK, S_DWELL, S_SAMPLE, S_DRAIN, S_STOP, S_FINISH
    } state_t;

    localparam logic [2:0]  CODE_PASS    = 3'd0;
    localparam logic [2:0]  CODE_TIMEOUT = 3'd1;
    localparam logic [2:0]  CODE_LOWSAMP = 3'd2;
    localparam logic [2:0]  CODE_ERRORS  = 3'd3;
    localparam logic [2:0]  CODE_CHAN    = 3'd4;
    localparam logic [2:0]  CODE_ABORT   = 3'd5;
    localparam logic [15:0] SETTLE_LOAD  = 16'(SETTLE_CYCLES - 1);
    localparam logic [15:0] LOCK_LOAD    = 16'(LOCK_TIMEOUT - 1);

    state_t      state_q, state_d;
    logic [15:0] cnt_q, cnt_d;
    logic [5:0]  rate_q, rate_d;
    logic [15:0] dwell_q, dwell_d;
    logic [15:0] drain_q, drain_d;
    logic [47:0] min_q, min_d;
    logic [2:0]  code_q, code_d;
    logic        gen_en_q, gen_en_d;
    logic        chk_en_q, chk_en_d;
    logic        loop_q, loop_d;
    logic [5:0]  gen_rate_q, gen_rate_d;
    logic        busy_q, busy_d;
    logic        done_q, done_d;
    logic        pass_q, pass_d;
    logic [2:0]  fail_code_q, fail_code_d;
    logic [47:0] res_samps_q, res_samps_d;
    logic [47:0] res_errors_q, res_errors_d;

    // Next-state, run bookkeeping and registered outputs derived from the next state
    always_comb begin
        state_d      = state_q;
        cnt_d        = cnt_q;
        rate_d       = rate_q;
        dwell_d      = dwell_q;
        drain_d      = drain_q;
        min_d        = min_q;
        code_d       = code_q;
        pass_d       = pass_q;
        fail_code_d  = fail_code_q;
        res_samps_d  = res_samps_q;
        res_errors_d = res_errors_q;

        case (state_q)
            S_IDLE: begin
                if (start) begin
                    rate_d       = rate;
                    dwell_d      = (dwell_cycles == 16'd0) ? 16'd1 : dwell_cycles;
                    drain_d      = drain_cycles;
                    min_d        = min_samps;
                    code_d       = CODE_PASS;
                    pass_d       = 1'b0;
                    res_samps_d  = '0;
                    res_errors_d = '0;
                    if (channel_up) begin
                        state_d = S_ARM;
                        cnt_d   = SETTLE_LOAD;
                    end else begin
                        code_d  = CODE_CHAN;
                        state_d = S_FINISH;
                    end
                end
            end
            S_STOP: begin
                if (abort && code_q == CODE_PASS) code_d = CODE_ABORT;
                state_d = S_FINISH;
            end
            S_FINISH: state_d = S_IDLE;
            default: begin
                // Abort outranks a channel drop; either one skips straight to STOP
                if (abort) begin
                    if (code_q == CODE_PASS) code_d = CODE_ABORT;
                    state_d = S_STOP;
                end else if (!channel_up) begin
                    if (code_q == CODE_PASS) code_d = CODE_CHAN;
                    res_samps_d  = '0;
                    res_errors_d = '0;
                    state_d      = S_STOP;
                end else begin
                    case (state_q)
                        S_ARM: begin
                            if (cnt_q == 16'd0) begin
                                state_d = S_LOCK;
                                cnt_d   = LOCK_LOAD;
                            end else cnt_d = cnt_q - 16'd1;
                        end
                        S_LOCK: begin
                            // Lock is checked before expiry so a simultaneous lock wins
                            if (bist_checker_locked) begin
                                state_d = S_DWELL;
                                cnt_d   = dwell_q - 16'd1;
                            end
`ifdef AURORA_BIST_SEQ_TIMEOUT_EN
                            else if (cnt_q == 16'd0) begin
                                code_d = CODE_TIMEOUT;
                                if (drain_q == 16'd0) state_d = S_STOP;
                                else begin
                                    state_d = S_DRAIN;
                                    cnt_d   = drain_q - 16'd1;
                                end
                            end else cnt_d = cnt_q - 16'd1;
`endif
                        end
                        S_DWELL: begin
                            if (cnt_q == 16'd0) begin
                                res_samps_d  = bist_checker_samps;
                                res_errors_d = bist_checker_errors;
                                state_d      = S_SAMPLE;
                            end else cnt_d = cnt_q - 16'd1;
                        end
                        S_SAMPLE: begin
                            if (code_q == CODE_PASS) begin
                                if (res_errors_q != 48'd0)   code_d = CODE_ERRORS;
                                else if (res_samps_q <= min_q) code_d = CODE_LOWSAMP;
                            end
                            if (drain_q == 16'd0) state_d = S_STOP;
                            else begin
                                state_d = S_DRAIN;
                                cnt_d   = drain_q - 16'd1;
                            end
                        end
                        S_DRAIN: begin
                            if (cnt_q == 16'd0) state_d = S_STOP;
                            else cnt_d = cnt_q - 16'd1;
                        end
                        default: state_d = state_q;
                    endcase
                end
            end
        endcase

        gen_en_d   = state_d inside {S_LOCK, S_DWELL, S_SAMPLE};
        chk_en_d   = state_d inside {S_LOCK, S_DWELL, S_SAMPLE, S_DRAIN};
        loop_d     = state_d inside {S_ARM, S_LOCK, S_DWELL, S_SAMPLE, S_DRAIN};
        busy_d     = state_d inside {S_ARM, S_LOCK, S_DWELL, S_SAMPLE, S_DRAIN, S_STOP};
        done_d     = (state_d == S_FINISH);
        gen_rate_d = gen_en_d ? rate_d : 6'd0;
        if (state_d == S_FINISH) begin
            fail_code_d = code_d;
            pass_d      = (code_d == CODE_PASS);
        end
    end

    // State and output registers; reset drops every BIST enable at once
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q      <= S_IDLE;
            cnt_q        <= '0;
            rate_q       <= '0;
            dwell_q      <= '0;
            drain_q      <= '0;
            min_q        <= '0;
            code_q       <= '0;
            gen_en_q     <= 1'b0;
            chk_en_q     <= 1'b0;
            loop_q       <= 1'b0;
            gen_rate_q   <= '0;
            busy_q       <= 1'b0;
            done_q       <= 1'b0;
            pass_q       <= 1'b0;
            fail_code_q  <= '0;
            res_samps_q  <= '0;
            res_errors_q <= '0;
        end else begin
            state_q      <= state_d;
            cnt_q        <= cnt_d;
            rate_q       <= rate_d;
            dwell_q      <= dwell_d;
            drain_q      <= drain_d;
            min_q        <= min_d;
            code_q       <= code_d;
            gen_en_q     <= gen_en_d;
            chk_en_q     <= chk_en_d;
            loop_q       <= loop_d;
            gen_rate_q   <= gen_rate_d;
            busy_q       <= busy_d;
            done_q       <= done_d;
            pass_q       <= pass_d;
            fail_code_q  <= fail_code_d;
            res_samps_q  <= res_samps_d;
            res_errors_q <= res_errors_d;
        end
    end

    assign bist_gen_en       = gen_en_q;
    assign bist_checker_en   = chk_en_q;
    assign bist_loopback_req = loop_q;
    assign bist_gen_rate     = gen_rate_q;
    assign busy              = busy_q;
    assign done              = done_q;
    assign pass              = pass_q;
    assign fail_code         = fail_code_q;
    assign result_samps      = res_samps_q;
    assign result_errors     = res_errors_q;

endmodule

// File: tb/tb_aurora_bist_seq.sv
// tb/tb_aurora_bist_seq.sv - directed and randomized runs of aurora_bist_seq against a timing/verdict model
module tb_aurora_bist_seq;
    localparam int SETTLE = 16;
    localparam int LTO    = 100;
    localparam int BIG    = 32'h3fff_ffff;

    logic        clk = 1'b0;
    logic        rst, start, abort, channel_up;
    logic [5:0]  rate;
    logic [15:0] dwell_cycles, drain_cycles;
    logic [47:0] min_samps;
    logic        gen_en, chk_en, loop;
    logic [5:0]  gen_rate;
    logic        locked;
    logic [47:0] samps_in, errors_in;
    logic        busy, done, pass;
    logic [2:0]  fail_code;
    logic [47:0] res_s, res_e;

    aurora_bist_seq #(.SETTLE_CYCLES(SETTLE), .LOCK_TIMEOUT(LTO)) dut (
        .clk(clk), .rst(rst), .start(start), .abort(abort), .channel_up(channel_up),
        .rate(rate), .dwell_cycles(dwell_cycles), .drain_cycles(drain_cycles),
        .min_samps(min_samps), .bist_gen_en(gen_en), .bist_checker_en(chk_en),
        .bist_loopback_req(loop), .bist_gen_rate(gen_rate),
        .bist_checker_locked(locked), .bist_checker_samps(samps_in),
        .bist_checker_errors(errors_in), .busy(busy), .done(done), .pass(pass),
        .fail_code(fail_code), .result_samps(res_s), .result_errors(res_e)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    // MAC model: sample counter ticks every cycle, lock follows gen-en by lat_v cycles
    logic [47:0] samp_base;
    int          lat_v, gen_rise, gen_fall, chk_fall, loop_rise, done_cyc, done_cnt, rate_err;
    bit          lock_ok, any_en, gen_p, chk_p, loop_p;
    logic [5:0]  rate_cur, rate_seen;
    int          ncmp = 0, nfail = 0;

    assign samps_in = samp_base + 48'(cyc);
    assign locked   = lock_ok && gen_en && (cyc >= gen_rise + lat_v);

    function automatic logic [2:0] verdict(input logic [47:0] e, input logic [47:0] s, input logic [47:0] mn);
        if (e != 48'd0) return 3'd3;
        if (s <= mn) return 3'd2;
        return 3'd0;
    endfunction

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        ncmp++;
        assert (obs === exp) else begin
            nfail++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    // One cycle, observed at the falling edge, with edge bookkeeping
    task automatic step();
        @(negedge clk);
        if (gen_en && !gen_p) begin gen_rise = cyc; rate_seen = gen_rate; end
        if (!gen_en && gen_p) gen_fall = cyc;
        if (!chk_en && chk_p) chk_fall = cyc;
        if (loop && !loop_p) loop_rise = cyc;
        if (done) begin done_cyc = cyc; done_cnt++; end
        if (gen_en || chk_en || loop) any_en = 1'b1;
        if (gen_rate !== (gen_en ? rate_cur : 6'd0)) rate_err++;
        gen_p = gen_en; chk_p = chk_en; loop_p = loop;
    endtask

    task automatic launch(input int dw, input int dr, input logic [5:0] rt, input logic [47:0] ev,
                          input int lat, input logic [47:0] mn_abs, input bit rel, input int delta,
                          output int s, output logic [47:0] mn);
        int d_eff;
        step();
        s     = cyc;
        d_eff = (dw == 0) ? 1 : dw;
        mn    = rel ? samp_base + 48'(s + SETTLE + 1 + lat + d_eff) - 48'd1 + 48'(delta + 1) : mn_abs;
        dwell_cycles = 16'(dw); drain_cycles = 16'(dr); rate = rt; rate_cur = rt;
        errors_in = ev; lat_v = lat; min_samps = mn;
        gen_rise = BIG; gen_fall = BIG; chk_fall = BIG; loop_rise = BIG; done_cyc = BIG;
        done_cnt = 0; any_en = 1'b0; rate_err = 0;
        start = 1'b1;
        step();
        start = 1'b0;
        rate = ~rt; dwell_cycles = 16'($urandom); drain_cycles = 16'($urandom);
        min_samps = 48'($urandom);
    endtask

    task automatic wait_done(input string nm, input int limit);
        for (int i = 0; i < limit && done_cnt == 0; i++) step();
        chk({nm, ":done_seen"}, 64'(done_cnt != 0), 64'd1);
    endtask

    task automatic normal_run(input string nm, input int dw, input int dr, input logic [5:0] rt,
                              input logic [47:0] ev, input int lat, input logic [47:0] mn_abs,
                              input bit rel, input int delta, input logic [47:0] base, input bit extra);
        int s, d_eff, g, r;
        logic [47:0] mn, es;
        logic [2:0]  ec;
        samp_base = base; lock_ok = 1'b1; channel_up = 1'b1;
        launch(dw, dr, rt, ev, lat, mn_abs, rel, delta, s, mn);
        chk({nm, ":busy_rise"}, 64'(busy), 64'd1);
        chk({nm, ":loop_rise"}, 64'(loop_rise), 64'(s + 1));
        if (extra) begin
            step(); start = 1'b1; step(); start = 1'b0;
        end
        wait_done(nm, 3000);
        d_eff = (dw == 0) ? 1 : dw;
        g  = s + SETTLE + 1;
        r  = g + lat + d_eff;
        es = base + 48'(r);
        ec = verdict(ev, es, mn);
        chk({nm, ":gen_rise"}, 64'(gen_rise), 64'(g));
        chk({nm, ":gen_fall"}, 64'(gen_fall), 64'(r + 2));
        chk({nm, ":chk_fall"}, 64'(chk_fall), 64'(r + 2 + dr));
        chk({nm, ":done_cyc"}, 64'(done_cyc), 64'(r + dr + 3));
        chk({nm, ":busy_at_done"}, 64'(busy), 64'd0);
        chk({nm, ":res_samps"}, 64'(res_s), 64'(es));
        chk({nm, ":res_errors"}, 64'(res_e), 64'(ev));
        chk({nm, ":fail_code"}, 64'(fail_code), 64'(ec));
        chk({nm, ":pass"}, 64'(pass), 64'(ec == 3'd0));
        chk({nm, ":rate_seen"}, 64'(rate_seen), 64'(rt));
        chk({nm, ":rate_track"}, 64'(rate_err), 64'd0);
        step();
        chk({nm, ":done_pulse"}, 64'(done), 64'd0);
    endtask

    initial begin : main
        int s, a, l;
        logic [47:0] mn;
        rst = 1'b1; start = 1'b0; abort = 1'b0; channel_up = 1'b1; rate = '0;
        dwell_cycles = '0; drain_cycles = '0; min_samps = '0; errors_in = '0;
        samp_base = '0; lat_v = 0; lock_ok = 1'b0; rate_cur = '0; rate_seen = '0;
        gen_rise = BIG; gen_fall = BIG; chk_fall = BIG; loop_rise = BIG; done_cyc = BIG;
        done_cnt = 0; rate_err = 0; any_en = 1'b0; gen_p = 1'b0; chk_p = 1'b0; loop_p = 1'b0;
        repeat (3) step();
        chk("rst:gen_en", 64'(gen_en), 64'd0);
        chk("rst:chk_en", 64'(chk_en), 64'd0);
        chk("rst:loop", 64'(loop), 64'd0);
        chk("rst:busy", 64'(busy), 64'd0);
        chk("rst:done", 64'(done), 64'd0);
        chk("rst:pass", 64'(pass), 64'd0);
        chk("rst:code", 64'(fail_code), 64'd0);
        chk("rst:res", 64'({res_s, 10'd0} | 64'(res_e)), 64'd0);
        chk("rst:rate", 64'(gen_rate), 64'd0);
        rst = 1'b0;
        step();

        normal_run("pass", 512, 256, 6'd60, 48'd0, 40, 48'd256, 1'b0, 0, 48'd0, 1'b1);
        normal_run("err", 100, 30, 6'd17, 48'd3, 5, 48'd10, 1'b0, 0, 48'h1000, 1'b0);
        normal_run("dw0_eqmin", 0, 4, 6'd5, 48'd0, 2, 48'd0, 1'b1, 0, 48'h77, 1'b0);
        for (int i = 0; i < 5; i++) begin
            normal_run("rnd", int'($urandom_range(0, 40)), int'($urandom_range(0, 20)),
                       6'($urandom), ($urandom_range(0, 2) == 0) ? 48'($urandom_range(1, 9)) : 48'd0,
                       int'($urandom_range(0, 8)), 48'd0, 1'b1, int'($urandom_range(0, 2)) - 1,
                       48'($urandom), i == 0);
        end

        // Start with the channel already down
        channel_up = 1'b0; lock_ok = 1'b1;
        launch(10, 10, 6'd9, 48'd0, 0, 48'd0, 1'b0, 0, s, mn);
        wait_done("cd_start", 3);
        chk("cd_start:done_cyc", 64'(done_cyc), 64'(s + 1));
        chk("cd_start:code", 64'(fail_code), 64'd4);
        chk("cd_start:pass", 64'(pass), 64'd0);
        chk("cd_start:no_enables", 64'(any_en), 64'd0);
        channel_up = 1'b1;
        step();

        // Channel drops at dwell cycle 200
        samp_base = 48'd5; lock_ok = 1'b1;
        launch(512, 256, 6'd33, 48'd0, 10, 48'd0, 1'b0, 0, s, mn);
        l = s + SETTLE + 1 + 10;
        for (int i = 0; i < 2000 && cyc < l + 200; i++) step();
        chk("drop:reach", 64'(cyc), 64'(l + 200));
        channel_up = 1'b0;
        step();
        chk("drop:gen_off", 64'(gen_en), 64'd0);
        chk("drop:chk_off", 64'(chk_en), 64'd0);
        wait_done("drop", 10);
        chk("drop:done_cyc", 64'(done_cyc), 64'(l + 202));
        chk("drop:code", 64'(fail_code), 64'd4);
        chk("drop:pass", 64'(pass), 64'd0);
        chk("drop:res", 64'(res_s | res_e), 64'd0);
        channel_up = 1'b1;
        step();

        // Lock never arrives
        lock_ok = 1'b0;
        launch(20, 7, 6'd3, 48'd0, 0, 48'd0, 1'b0, 0, s, mn);
`ifdef AURORA_BIST_SEQ_TIMEOUT_EN
        wait_done("timeout", 1000);
        chk("timeout:gen_fall", 64'(gen_fall), 64'(s + SETTLE + 1 + LTO));
        chk("timeout:done_cyc", 64'(done_cyc), 64'(s + SETTLE + 1 + LTO + 7 + 1));
        chk("timeout:code", 64'(fail_code), 64'd1);
`else
        repeat (300) step();
        chk("nolock:busy", 64'(busy), 64'd1);
        chk("nolock:gen_en", 64'(gen_en), 64'd1);
        chk("nolock:no_done", 64'(done_cnt), 64'd0);
        abort = 1'b1;
        a = cyc;
        step();
        chk("abort:gen_off", 64'(gen_en), 64'd0);
        chk("abort:loop_off", 64'(loop), 64'd0);
        abort = 1'b0;
        wait_done("abort", 10);
        chk("abort:done_cyc", 64'(done_cyc), 64'(a + 2));
        chk("abort:code", 64'(fail_code), 64'd5);
`endif
        chk("nolock:pass", 64'(pass), 64'd0);
        step();

        // Reset in the middle of DWELL
        lock_ok = 1'b1; samp_base = 48'd0;
        launch(400, 10, 6'd12, 48'd0, 3, 48'd0, 1'b0, 0, s, mn);
        repeat (100) step();
        chk("mid:in_dwell", 64'(gen_en), 64'd1);
        rst = 1'b1;
        #1;
        chk("mid_rst:gen_en", 64'(gen_en), 64'd0);
        chk("mid_rst:chk_en", 64'(chk_en), 64'd0);
        chk("mid_rst:loop", 64'(loop), 64'd0);
        chk("mid_rst:busy", 64'(busy), 64'd0);
        chk("mid_rst:rate", 64'(gen_rate), 64'd0);
        chk("mid_rst:code", 64'(fail_code), 64'd0);
        chk("mid_rst:pass_done", 64'({pass, done}), 64'd0);
        repeat (2) step();
        rst = 1'b0;
        step();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", ncmp, nfail);
        $finish;
    end
endmodule
